// File: rtl/serial_adder_if.sv
// Start/done handshake bundle for serial_adder: operands in, busy/done/result out.
// With SERIAL_ADDER_SUB_EN defined the bundle also carries the sub_i select.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cin_i;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub_i;
`endif
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start_i, a_i, b_i, cin_i, sub_i,
                    input  busy_o, done_o, sum_o, cout_o);
    modport slave  (input  start_i, a_i, b_i, cin_i, sub_i,
                    output busy_o, done_o, sum_o, cout_o);
`else
    modport master (output start_i, a_i, b_i, cin_i,
                    input  busy_o, done_o, sum_o, cout_o);
    modport slave  (input  start_i, a_i, b_i, cin_i,
                    output busy_o, done_o, sum_o, cout_o);
`endif
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder: DIGIT bits per clock with a registered carry, WIDTH/DIGIT steps per op.
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds sub_i, computing a + ~b + 1).
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic          clk,
    input logic          rst,
    serial_adder_if.slave bus
);
    localparam int STEPS = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (DIGIT < 1 || WIDTH < DIGIT || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] acc_shift;
    logic             last_step;

    // One digit of the sum; the new digit enters the accumulator from the top.
    always_comb begin
        dsum      = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, carry_q};
        acc_shift = (acc_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
        last_step = (cnt_q == CNT_W'(STEPS - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    a_d     = bus.a_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SERIAL_ADDER_SUB_EN
                    // Subtraction is a + ~b + 1, so the inverted B and a forced carry are captured.
                    b_d     = bus.sub_i ? ~bus.b_i : bus.b_i;
                    carry_d = bus.sub_i ? 1'b1 : bus.cin_i;
`else
                    b_d     = bus.b_i;
                    carry_d = bus.cin_i;
`endif
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = acc_shift;
                carry_d = dsum[DIGIT];
                cnt_d   = cnt_q + 1'b1;
                if (last_step) begin
                    sum_d   = acc_shift;
                    cout_d  = dsum[DIGIT];
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy_o = (state_q == RUN);
    assign bus.done_o = done_q;
    assign bus.sum_o  = sum_q;
    assign bus.cout_o = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three configurations (1x1, 8x1, 8x4) against an arithmetic model.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(1)) if1  ();
    serial_adder_if #(.WIDTH(8)) if8a ();
    serial_adder_if #(.WIDTH(8)) if8b ();

    serial_adder #(.WIDTH(1), .DIGIT(1)) u_w1   (.clk(clk), .rst(rst), .bus(if1));
    serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (.clk(clk), .rst(rst), .bus(if8a));
    serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (.clk(clk), .rst(rst), .bus(if8b));

    // w selects the DUT: 0 = 1x1, 1 = 8x1, 2 = 8x4
    task automatic drive(input int w, input logic st, input logic [7:0] a, input logic [7:0] b,
                         input logic c);
        case (w)
            0:       begin if1.start_i  = st; if1.a_i  = a[0]; if1.b_i  = b[0]; if1.cin_i  = c; end
            1:       begin if8a.start_i = st; if8a.a_i = a;    if8a.b_i = b;    if8a.cin_i = c; end
            default: begin if8b.start_i = st; if8b.a_i = a;    if8b.b_i = b;    if8b.cin_i = c; end
        endcase
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic set_sub(input logic s);
        if1.sub_i = s; if8a.sub_i = s; if8b.sub_i = s;
    endtask
`endif

    function automatic logic get_done(input int w);
        case (w) 0: return if1.done_o; 1: return if8a.done_o; default: return if8b.done_o; endcase
    endfunction
    function automatic logic get_busy(input int w);
        case (w) 0: return if1.busy_o; 1: return if8a.busy_o; default: return if8b.busy_o; endcase
    endfunction
    function automatic logic [7:0] get_sum(input int w);
        case (w) 0: return {7'b0, if1.sum_o}; 1: return if8a.sum_o; default: return if8b.sum_o; endcase
    endfunction
    function automatic logic get_cout(input int w);
        case (w) 0: return if1.cout_o; 1: return if8a.cout_o; default: return if8b.cout_o; endcase
    endfunction

    // Called at a falling edge; returns at the falling edge where done is seen (or a bound expires).
    task automatic do_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic c,
                         output logic [7:0] sm, output logic co, output int lat, output int bcy,
                         output logic bsy_done, output logic moved);
        logic [7:0] s0;
        logic       c0;
        s0 = get_sum(w);
        c0 = get_cout(w);
        drive(w, 1'b1, a, b, c);
        @(negedge clk);
        drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        lat = 0; bcy = 0; moved = 1'b0;
        while (!get_done(w) && lat < 40) begin
            if (get_busy(w)) bcy++;
            if (get_sum(w) !== s0 || get_cout(w) !== c0) moved = 1'b1;
            @(negedge clk);
            lat++;
        end
        sm = get_sum(w); co = get_cout(w); bsy_done = get_busy(w);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            n_chk++;
            if ({get_busy(w), get_done(w), get_sum(w), get_cout(w)} !== 11'd0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: busy=%b done=%b sum=%h cout=%b, required all 0",
                         w, get_busy(w), get_done(w), get_sum(w), get_cout(w));
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_adder_table();
        logic [7:0] sm; logic co, bd, mv; int lat, bcy;
        logic [1:0] e;
        for (int i = 0; i < 8; i++) begin
            e = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
            do_op(0, {7'b0, i[2]}, {7'b0, i[1]}, i[0], sm, co, lat, bcy, bd, mv);
            n_chk++;
            if ({co, sm[0]} !== e || lat != 1) begin
                n_fail++;
                $display("FAIL full_adder %0d%0d%0d: cout,sum=%b%b lat=%0d, required %b lat=1",
                         i[2], i[1], i[0], co, sm[0], lat, e);
            end
        end
    endtask

    task automatic test_directed_w8d1();
        logic [7:0] sm; logic co, bd, mv; int lat, bcy;
        do_op(1, 8'hFF, 8'h01, 1'b0, sm, co, lat, bcy, bd, mv);
        n_chk++;
        if ({co, sm} !== 9'h100) begin
            n_fail++; $display("FAIL ff_plus_01: got %b_%h, required 1_00", co, sm);
        end
        n_chk++;
        if (lat != 8 || bcy != 8 || bd !== 1'b0) begin
            n_fail++;
            $display("FAIL ff_plus_01 timing: lat=%0d busy_cycles=%0d busy_at_done=%b, required 8/8/0",
                     lat, bcy, bd);
        end
    endtask

    task automatic test_random();
        logic [7:0] sm, a, b; logic co, c, bd, mv; int lat, bcy;
        logic [8:0] e;
        for (int w = 1; w < 3; w++) begin
            for (int k = 0; k < 25; k++) begin
                a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
                e = {1'b0, a} + {1'b0, b} + 9'(c);
                do_op(w, a, b, c, sm, co, lat, bcy, bd, mv);
                n_chk++;
                if ({co, sm} !== e || lat != ((w == 1) ? 8 : 2) || mv !== 1'b0) begin
                    n_fail++;
                    $display("FAIL random dut%0d %h+%h+%b: got %b_%h lat=%0d moved=%b, required %b_%h",
                             w, a, b, c, co, sm, lat, mv, e[8], e[7:0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] sm; logic co, bd, mv; int lat, bcy;
        do_op(2, 8'h7F, 8'h80, 1'b1, sm, co, lat, bcy, bd, mv);
        n_chk++;
        if ({co, sm} !== 9'h100 || lat != 2) begin
            n_fail++; $display("FAIL b2b_first: got %b_%h lat=%0d, required 1_00 lat=2", co, sm, lat);
        end
        do_op(2, 8'h12, 8'h34, 1'b0, sm, co, lat, bcy, bd, mv);
        n_chk++;
        if ({co, sm} !== 9'h046 || lat != 2) begin
            n_fail++; $display("FAIL b2b_second: got %b_%h lat=%0d, required 0_46 lat=2", co, sm, lat);
        end
        @(negedge clk);
        n_chk++;
        if (get_done(2) !== 1'b0) begin
            n_fail++; $display("FAIL done_width: done=%b one cycle later, required 0", get_done(2));
        end
    endtask

    task automatic test_start_ignored();
        logic [7:0] a1, b1, sm; logic c1, co; int ndone;
        logic [8:0] e;
        a1 = 8'($urandom); b1 = 8'($urandom); c1 = 1'($urandom);
        e  = {1'b0, a1} + {1'b0, b1} + 9'(c1);
        sm = 8'h00; co = 1'b0; ndone = 0;
        drive(1, 1'b1, a1, b1, c1);
        @(negedge clk);
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        drive(1, 1'b1, ~a1, a1 ^ 8'h5A, ~c1);
        @(negedge clk);
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (get_done(1)) begin ndone++; sm = get_sum(1); co = get_cout(1); end
            @(negedge clk);
        end
        n_chk++;
        if (ndone != 1 || {co, sm} !== e) begin
            n_fail++;
            $display("FAIL start_in_run: dones=%0d result=%b_%h, required 1 done with %b_%h",
                     ndone, co, sm, e[8], e[7:0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] sm; logic co, bd, mv; int lat, bcy, ndone;
        do_op(1, 8'hF0, 8'h20, 1'b0, sm, co, lat, bcy, bd, mv);
        n_chk++;
        if ({co, sm} !== 9'h110) begin
            n_fail++; $display("FAIL pre_reset_op: got %b_%h, required 1_10", co, sm);
        end
        @(negedge clk);
        drive(1, 1'b1, 8'h55, 8'h22, 1'b0);
        @(negedge clk);
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({if8a.busy_o, if8a.done_o, if8a.sum_o, if8a.cout_o} !== 11'd0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b done=%b sum=%h cout=%b, required all 0",
                     if8a.busy_o, if8a.done_o, if8a.sum_o, if8a.cout_o);
        end
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (get_done(1)) ndone++;
            @(negedge clk);
        end
        n_chk++;
        if (ndone != 0) begin
            n_fail++; $display("FAIL reset_discard: dones=%0d after reset, required 0", ndone);
        end
        do_op(1, 8'h3C, 8'h4D, 1'b1, sm, co, lat, bcy, bd, mv);
        n_chk++;
        if ({co, sm} !== 9'h08A || lat != 8) begin
            n_fail++; $display("FAIL post_reset_op: got %b_%h lat=%0d, required 0_8a lat=8", co, sm, lat);
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        logic [7:0] sm, a, b; logic co, bd, mv; int lat, bcy;
        logic [8:0] e;
        set_sub(1'b1);
        for (int w = 1; w < 3; w++) begin
            do_op(w, 8'h05, 8'h07, 1'b0, sm, co, lat, bcy, bd, mv);
            n_chk++;
            if ({co, sm} !== 9'h0FE) begin
                n_fail++; $display("FAIL sub_05_07 dut%0d: got %b_%h, required 0_fe", w, co, sm);
            end
            do_op(w, 8'h07, 8'h05, 1'b0, sm, co, lat, bcy, bd, mv);
            n_chk++;
            if ({co, sm} !== 9'h102) begin
                n_fail++; $display("FAIL sub_07_05 dut%0d: got %b_%h, required 1_02", w, co, sm);
            end
            for (int k = 0; k < 10; k++) begin
                a = 8'($urandom); b = 8'($urandom);
                e = {1'b0, a} + {1'b0, ~b} + 9'd1;
                do_op(w, a, b, 1'($urandom), sm, co, lat, bcy, bd, mv);
                n_chk++;
                if ({co, sm} !== e || co !== (a >= b)) begin
                    n_fail++;
                    $display("FAIL sub_random dut%0d %h-%h: got %b_%h, required %b_%h",
                             w, a, b, co, sm, e[8], e[7:0]);
                end
            end
        end
        set_sub(1'b0);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int w = 0; w < 3; w++) drive(w, 1'b0, 8'h00, 8'h00, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
        set_sub(1'b0);
`endif
        test_reset();
        test_full_adder_table();
        test_directed_w8d1();
        test_random();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
